ysyx_23060077_axi_rr_arbiter: RTL and testbench
===============================================

// Module: ysyx_23060077_axi_rr_arbiter
// PURPOSE
//  Parametrised AXI4 master-side arbiter: NUM_CLI read clients and NUM_CLI write clients share one AXI master port.
//  Independent read and write FSMs, each granting one client at a time (round-robin), one outstanding burst per channel.
//  Sits between IFU/LSU client ports and io_master_*; successor of the fixed 2-client IFU/LSU arbiter.
// PARAMETERS
//  NUM_CLI  2   number of clients per channel (>=2); client index is also used as AXI ID
//  ADDR_W   32  address width
//  DATA_W   32  data width (32 or 64); strobe width DATA_W/8
//  LEN_W    8   AXI len width (beats-1)
//  ID_W     4   AXI ID width; NUM_CLI <= 2**ID_W
// PORTS
//  aclk        in   1                 clock
//  areset_n    in   1                 async active-low reset
//  cli_r_valid_i in NUM_CLI           read request, held until the client's last beat
//  cli_r_addr_i  in NUM_CLI*ADDR_W    read address (client k at [k*ADDR_W+:ADDR_W])
//  cli_r_len_i   in NUM_CLI*LEN_W     read burst len
//  cli_r_ready_o out NUM_CLI          one-cycle pulse per returned beat
//  cli_r_data_o  out DATA_W           returned beat data (valid with cli_r_ready_o)
//  cli_r_last_o  out NUM_CLI          pulse with final beat
//  cli_w_valid_i in NUM_CLI           write request, held until cli_w_last_o
//  cli_w_addr_i/len_i in NUM_CLI*ADDR_W / NUM_CLI*LEN_W
//  cli_w_data_i  in NUM_CLI*DATA_W    current write beat
//  cli_w_size_i  in NUM_CLI*3         AXI size of write
//  cli_w_ready_o out NUM_CLI          pulse when current beat accepted; client presents next beat
//  cli_w_last_o  out NUM_CLI          pulse on B response
//  axi_ar_* / axi_r_* / axi_aw_* / axi_w_* / axi_b_*  standard AXI4 master signals (valid,ready,addr,id,len,size,burst,data,strb,last,resp)
// BEHAVIOUR
//  Reset (async, areset_n=0): all valid/ready/last outputs 0, FSMs IDLE, RR pointers 0, beat counter 0; outputs in-flight are dropped.
//  Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
//   R_IDLE: if any cli_r_valid_i, grant first requester at/after rd_ptr (wrap NUM_CLI-1 -> 0); register grant, addr, len; next R_AR.
//   R_AR: axi_ar_valid=1, arid=grant, arsize=log2(DATA_W/8), arburst=2'b01; stays until ar_ready (valid never drops early).
//   R_DATA: axi_r_ready=1; each r_valid -> cli_r_ready_o[grant]=1 same cycle, data combinationally forwarded.
//   r_valid&r_last -> cli_r_last_o[grant]=1, rd_ptr=grant+1 (mod NUM_CLI), R_IDLE. r_resp ignored.
//  Write FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
//   Grant identical to read, with separate wr_ptr. W_AW: awvalid until aw_ready; awsize=cli_w_size_i[grant].
//   W_DATA: wvalid=1, wdata=cli_w_data_i[grant]; wstrb = size mask shifted by addr[log2(DATA_W/8)-1:0];
//    beat counter from 0; wlast when counter==len; each w_valid&w_ready -> cli_w_ready_o[grant] pulse, counter++.
//   Last beat accepted -> W_RESP: bready=1; b_valid -> cli_w_last_o[grant] pulse, wr_ptr advances, W_IDLE.
//  Grant latency: request seen in IDLE -> ar/aw valid next cycle; minimum read turnaround 1 idle cycle between bursts.
//  Read and write channels run concurrently; same client may hold both. Client dropping valid mid-burst is illegal (not handled).
//  No combinational path from axi_*_ready to axi_*_valid.
// CONFIGURATION
//  AXI_ARB_FIXED_PRIO_EN defined: pointers unused, lowest-index requester always wins (IFU=0 highest).
//  Undefined (default): round-robin as above; a continuously requesting client waits at most NUM_CLI-1 bursts.
// TESTING
//  1) Single read, client1 addr 0x8000_0010 len 3 -> arid=1, 4 r beats each pulse cli_r_ready_o[1], last pulse on beat 4.
//  2) NUM_CLI=3 all reads held -> grant order 0,1,2,0; with FIXED_PRIO_EN -> 0,0,0.
//  3) Write size=0 addr 0x...03 DATA_W=32 data 0xAB -> wstrb=4'b1000, wlast=1, cli_w_last_o on bvalid after bready.
//  4) Write len=1 with w_ready stalled 3 cycles -> wdata/wvalid stable, two cli_w_ready_o pulses, wlast on beat 2 only.
//  5) Concurrent read(client0) and write(client1) -> both complete, no channel blocks the other.
//  6) areset_n low during R_DATA beat 2 -> all outputs 0 async, next grant from rd_ptr=0.

Source files
------------

// File: rtl/ysyx_23060077_axi_rr_arbiter.sv
// ysyx_23060077_axi_rr_arbiter
// AXI4 master-side arbiter: NUM_CLI read clients and NUM_CLI write clients
// share one AXI master port. Read and write channels have independent FSMs,
// each serving one burst at a time. The client index is used as the AXI ID.
// Optional build macro: AXI_ARB_FIXED_PRIO_EN -- lowest-index requester always
// wins instead of round-robin (the pointers keep updating but are ignored).
module ysyx_23060077_axi_rr_arbiter #(
    parameter int NUM_CLI = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8,
    parameter int ID_W    = 4
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    // read clients
    input  logic [NUM_CLI-1:0]         cli_r_valid_i,
    input  logic [NUM_CLI*ADDR_W-1:0]  cli_r_addr_i,
    input  logic [NUM_CLI*LEN_W-1:0]   cli_r_len_i,
    output logic [NUM_CLI-1:0]         cli_r_ready_o,
    output logic [DATA_W-1:0]          cli_r_data_o,
    output logic [NUM_CLI-1:0]         cli_r_last_o,
    // write clients
    input  logic [NUM_CLI-1:0]         cli_w_valid_i,
    input  logic [NUM_CLI*ADDR_W-1:0]  cli_w_addr_i,
    input  logic [NUM_CLI*LEN_W-1:0]   cli_w_len_i,
    input  logic [NUM_CLI*DATA_W-1:0]  cli_w_data_i,
    input  logic [NUM_CLI*3-1:0]       cli_w_size_i,
    output logic [NUM_CLI-1:0]         cli_w_ready_o,
    output logic [NUM_CLI-1:0]         cli_w_last_o,
    // AXI AR
    output logic                       axi_ar_valid,
    input  logic                       axi_ar_ready,
    output logic [ADDR_W-1:0]          axi_ar_addr,
    output logic [ID_W-1:0]            axi_ar_id,
    output logic [LEN_W-1:0]           axi_ar_len,
    output logic [2:0]                 axi_ar_size,
    output logic [1:0]                 axi_ar_burst,
    // AXI R
    input  logic                       axi_r_valid,
    output logic                       axi_r_ready,
    input  logic [DATA_W-1:0]          axi_r_data,
    input  logic [1:0]                 axi_r_resp,
    input  logic                       axi_r_last,
    input  logic [ID_W-1:0]            axi_r_id,
    // AXI AW
    output logic                       axi_aw_valid,
    input  logic                       axi_aw_ready,
    output logic [ADDR_W-1:0]          axi_aw_addr,
    output logic [ID_W-1:0]            axi_aw_id,
    output logic [LEN_W-1:0]           axi_aw_len,
    output logic [2:0]                 axi_aw_size,
    output logic [1:0]                 axi_aw_burst,
    // AXI W
    output logic                       axi_w_valid,
    input  logic                       axi_w_ready,
    output logic [DATA_W-1:0]          axi_w_data,
    output logic [DATA_W/8-1:0]        axi_w_strb,
    output logic                       axi_w_last,
    // AXI B
    input  logic                       axi_b_valid,
    output logic                       axi_b_ready,
    input  logic [1:0]                 axi_b_resp,
    input  logic [ID_W-1:0]            axi_b_id
);

    localparam int IDX_W  = $clog2(NUM_CLI);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [2:0] BUS_SIZE = 3'($clog2(STRB_W));

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    // per-client views of the flattened client buses
    logic [NUM_CLI-1:0][ADDR_W-1:0] r_addr_a, w_addr_a;
    logic [NUM_CLI-1:0][LEN_W-1:0]  r_len_a, w_len_a;
    logic [NUM_CLI-1:0][DATA_W-1:0] w_data_a;
    logic [NUM_CLI-1:0][2:0]        w_size_a;

    assign r_addr_a = cli_r_addr_i;
    assign r_len_a  = cli_r_len_i;
    assign w_addr_a = cli_w_addr_i;
    assign w_len_a  = cli_w_len_i;
    assign w_data_a = cli_w_data_i;
    assign w_size_a = cli_w_size_i;

    // response status and IDs are not propagated: one burst in flight per channel
    logic unused_ok;
    assign unused_ok = ^{axi_r_resp, axi_r_id, axi_b_resp, axi_b_id};

    // first requester at or after ptr, wrapping past NUM_CLI-1
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLI-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        int j;
        sel = '0;
        for (int i = NUM_CLI - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_CLI) j = j - NUM_CLI;
            if (req[j]) sel = IDX_W'(j);
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_CLI - 1) ? '0 : g + 1'b1;
    endfunction

    logic [1:0]        r_state, w_state;
    logic [IDX_W-1:0]  rd_ptr, wr_ptr, r_grant, w_grant, r_pick, w_pick;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [LEN_W-1:0]  r_len, w_len, w_beat;
    logic [2:0]        w_size;
    logic [NUM_CLI-1:0] r_onehot, w_onehot;
    logic [STRB_W-1:0] size_mask;

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign r_pick = rr_pick(cli_r_valid_i, '0);
    assign w_pick = rr_pick(cli_w_valid_i, '0);
`else
    assign r_pick = rr_pick(cli_r_valid_i, rd_ptr);
    assign w_pick = rr_pick(cli_w_valid_i, wr_ptr);
`endif

    // read channel: grant, address phase, then forward beats until r_last
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_grant <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            rd_ptr  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (|cli_r_valid_i) begin
                    r_grant <= r_pick;
                    r_addr  <= r_addr_a[r_pick];
                    r_len   <= r_len_a[r_pick];
                    r_state <= R_AR;
                end
                R_AR:   if (axi_ar_ready) r_state <= R_DATA;
                R_DATA: if (axi_r_valid && axi_r_last) begin
                    rd_ptr  <= ptr_inc(r_grant);
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign r_onehot     = {{(NUM_CLI-1){1'b0}}, 1'b1} << r_grant;
    assign axi_ar_valid = (r_state == R_AR);
    assign axi_ar_addr  = r_addr;
    assign axi_ar_id    = ID_W'(r_grant);
    assign axi_ar_len   = r_len;
    assign axi_ar_size  = BUS_SIZE;
    assign axi_ar_burst = 2'b01;
    assign axi_r_ready  = (r_state == R_DATA);
    assign cli_r_ready_o = (axi_r_ready && axi_r_valid) ? r_onehot : '0;
    assign cli_r_last_o  = (axi_r_ready && axi_r_valid && axi_r_last) ? r_onehot : '0;
    assign cli_r_data_o  = axi_r_data;

    // write channel: grant, address phase, counted data beats, B response
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            w_grant <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_beat  <= '0;
            wr_ptr  <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (|cli_w_valid_i) begin
                    w_grant <= w_pick;
                    w_addr  <= w_addr_a[w_pick];
                    w_len   <= w_len_a[w_pick];
                    w_size  <= w_size_a[w_pick];
                    w_beat  <= '0;
                    w_state <= W_AW;
                end
                W_AW:   if (axi_aw_ready) w_state <= W_DATA;
                W_DATA: if (axi_w_ready) begin
                    w_beat <= w_beat + 1'b1;
                    if (w_beat == w_len) w_state <= W_RESP;
                end
                W_RESP: if (axi_b_valid) begin
                    wr_ptr  <= ptr_inc(w_grant);
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // byte-lane mask for the transfer size, placed at the address offset
    always_comb begin
        size_mask = '0;
        for (int b = 0; b < STRB_W; b++)
            size_mask[b] = (b < (1 << w_size));
        axi_w_strb = size_mask << w_addr[OFF_W-1:0];
    end

    assign w_onehot      = {{(NUM_CLI-1){1'b0}}, 1'b1} << w_grant;
    assign axi_aw_valid  = (w_state == W_AW);
    assign axi_aw_addr   = w_addr;
    assign axi_aw_id     = ID_W'(w_grant);
    assign axi_aw_len    = w_len;
    assign axi_aw_size   = w_size;
    assign axi_aw_burst  = 2'b01;
    assign axi_w_valid   = (w_state == W_DATA);
    assign axi_w_data    = w_data_a[w_grant];
    assign axi_w_last    = axi_w_valid && (w_beat == w_len);
    assign axi_b_ready   = (w_state == W_RESP);
    assign cli_w_ready_o = (axi_w_valid && axi_w_ready) ? w_onehot : '0;
    assign cli_w_last_o  = (axi_b_ready && axi_b_valid) ? w_onehot : '0;

endmodule

// File: tb/tb_ysyx_23060077_axi_rr_arbiter.sv
// Directed bench for ysyx_23060077_axi_rr_arbiter with three clients.
module tb_ysyx_23060077_axi_rr_arbiter;
    localparam int N = 3, AW = 32, DW = 32, LW = 8, IW = 4;

    logic aclk = 1'b0, areset_n = 1'b0;
    logic [N-1:0] cli_r_valid, cli_r_ready, cli_r_last, cli_w_valid, cli_w_ready, cli_w_last;
    logic [N*AW-1:0] cli_r_addr, cli_w_addr;
    logic [N*LW-1:0] cli_r_len, cli_w_len;
    logic [N*DW-1:0] cli_w_data;
    logic [N*3-1:0]  cli_w_size;
    logic [DW-1:0]   cli_r_data;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last, aw_valid, aw_ready;
    logic w_valid, w_ready, w_last, b_valid, b_ready;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [IW-1:0] ar_id, aw_id, r_id, b_id;
    logic [LW-1:0] ar_len, aw_len;
    logic [2:0] ar_size, aw_size;
    logic [1:0] ar_burst, aw_burst, r_resp, b_resp;
    logic [DW-1:0] r_data, w_data;
    logic [DW/8-1:0] w_strb;

    always #5 aclk = ~aclk;

    ysyx_23060077_axi_rr_arbiter #(.NUM_CLI(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .cli_r_valid_i(cli_r_valid), .cli_r_addr_i(cli_r_addr), .cli_r_len_i(cli_r_len),
        .cli_r_ready_o(cli_r_ready), .cli_r_data_o(cli_r_data), .cli_r_last_o(cli_r_last),
        .cli_w_valid_i(cli_w_valid), .cli_w_addr_i(cli_w_addr), .cli_w_len_i(cli_w_len),
        .cli_w_data_i(cli_w_data), .cli_w_size_i(cli_w_size),
        .cli_w_ready_o(cli_w_ready), .cli_w_last_o(cli_w_last),
        .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_addr(ar_addr), .axi_ar_id(ar_id),
        .axi_ar_len(ar_len), .axi_ar_size(ar_size), .axi_ar_burst(ar_burst),
        .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_data(r_data), .axi_r_resp(r_resp),
        .axi_r_last(r_last), .axi_r_id(r_id),
        .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_addr(aw_addr), .axi_aw_id(aw_id),
        .axi_aw_len(aw_len), .axi_aw_size(aw_size), .axi_aw_burst(aw_burst),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_data(w_data), .axi_w_strb(w_strb),
        .axi_w_last(w_last),
        .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_resp(b_resp), .axi_b_id(b_id)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick; @(posedge aclk); #1; endtask

    task automatic wait_ar(output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while (!ar_valid && cyc < 20);
    endtask

    task automatic wait_aw(output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end while (!aw_valid && cyc < 20);
    endtask

    // one read burst as seen from the slave side; beat k carries data base+k
    task automatic rd_burst(input int id, input logic [31:0] addr, input int beats, input logic [31:0] base);
        int cyc;
        wait_ar(cyc);
        chk("ar_latency", cyc, 1);
        chk("ar_id", ar_id, id);
        chk("ar_addr", ar_addr, addr);
        chk("ar_len", ar_len, beats - 1);
        chk("ar_size", ar_size, 2);
        chk("ar_burst", ar_burst, 1);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        #1;
        chk("ar_valid_drop", ar_valid, 0);
        chk("r_ready", r_ready, 1);
        for (int b = 0; b < beats; b++) begin
            r_valid = 1'b1; r_data = base + b; r_last = (b == beats - 1);
            #1;
            chk("cli_r_ready", cli_r_ready, 1 << id);
            chk("cli_r_data", cli_r_data, base + b);
            chk("cli_r_last", cli_r_last, (b == beats - 1) ? (1 << id) : 0);
            tick();
        end
        r_valid = 1'b0; r_last = 1'b0;
    endtask

    // B phase of a write for client id
    task automatic b_phase(input int id);
        #1;
        chk("w_valid_drop", w_valid, 0);
        chk("b_ready", b_ready, 1);
        chk("cli_w_last_early", cli_w_last, 0);
        b_valid = 1'b1;
        #1;
        chk("cli_w_last", cli_w_last, 1 << id);
        tick();
        b_valid = 1'b0;
    endtask

    typedef struct {
        int          cli;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
    } wvec_t;
    wvec_t wv[6];
    int rr_exp[4];

    initial begin
        int cyc;
        wv[0] = '{1, 32'h0000_1003, 3'd0, 32'h0000_00AB, 4'b1000};
        wv[1] = '{0, 32'h0000_1000, 3'd0, 32'h0000_0012, 4'b0001};
        wv[2] = '{2, 32'h0000_1002, 3'd1, 32'h3456_0000, 4'b1100};
        wv[3] = '{0, 32'h0000_1001, 3'd0, 32'h0000_7800, 4'b0010};
        wv[4] = '{1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF, 4'b1111};
        wv[5] = '{2, 32'h0000_1000, 3'd1, 32'h0000_CAFE, 4'b0011};
`ifdef AXI_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 0};
`endif
        cli_r_valid = '0; cli_r_addr = '0; cli_r_len = '0;
        cli_w_valid = '0; cli_w_addr = '0; cli_w_len = '0; cli_w_data = '0; cli_w_size = '0;
        ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0; r_last = 0; r_id = '0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0; b_id = '0;

        // reset state
        #12;
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_r_ready", r_ready, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_cli_r_ready", cli_r_ready, 0);
        chk("rst_cli_w_ready", cli_w_ready, 0);
        tick();
        areset_n = 1'b1;
        tick();

        // single read, client 1, 4 beats
        cli_r_valid = 3'b010;
        cli_r_addr[AW +: AW] = 32'h8000_0010;
        cli_r_len[LW +: LW] = 8'd3;
        rd_burst(1, 32'h8000_0010, 4, 32'h5500_0000);
        cli_r_valid = '0;
        #1;
        chk("r_idle_after_last", r_ready, 0);

        // async reset during beat 2 of a read
        cli_r_valid = 3'b010;
        wait_ar(cyc);
        chk("rst6_ar_latency", cyc, 1);
        ar_ready = 1'b1; tick(); ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 32'h1; r_last = 1'b0;
        tick();
        r_data = 32'h2;
        #2;
        areset_n = 1'b0;
        #1;
        chk("arst_cli_r_ready", cli_r_ready, 0);
        chk("arst_cli_r_last", cli_r_last, 0);
        chk("arst_r_ready", r_ready, 0);
        chk("arst_ar_valid", ar_valid, 0);
        chk("arst_b_ready", b_ready, 0);
        r_valid = 1'b0; cli_r_valid = '0;
        tick();
        areset_n = 1'b1;
        tick();

        // all three read clients held; pointer restarts at 0 after reset
        for (int k = 0; k < N; k++) begin
            cli_r_addr[k*AW +: AW] = 32'h1000_0000 + k * 32'h100;
            cli_r_len[k*LW +: LW] = 8'd0;
        end
        cli_r_valid = 3'b111;
        for (int i = 0; i < 4; i++)
            rd_burst(rr_exp[i], 32'h1000_0000 + rr_exp[i] * 32'h100, 1, 32'hA000_0000 + i);
        cli_r_valid = '0;

        // single-beat write strobe vectors
        foreach (wv[i]) begin
            cli_w_valid = '0; cli_w_addr = '0; cli_w_size = '0; cli_w_data = '0; cli_w_len = '0;
            cli_w_valid[wv[i].cli] = 1'b1;
            cli_w_addr[wv[i].cli*AW +: AW] = wv[i].addr;
            cli_w_size[wv[i].cli*3 +: 3] = wv[i].size;
            cli_w_data[wv[i].cli*DW +: DW] = wv[i].data;
            wait_aw(cyc);
            chk("aw_latency", cyc, 1);
            chk("aw_id", aw_id, wv[i].cli);
            chk("aw_addr", aw_addr, wv[i].addr);
            chk("aw_size", aw_size, wv[i].size);
            chk("aw_len", aw_len, 0);
            chk("aw_burst", aw_burst, 1);
            aw_ready = 1'b1; tick(); aw_ready = 1'b0;
            #1;
            chk("w_valid", w_valid, 1);
            chk("aw_valid_drop", aw_valid, 0);
            chk("w_data", w_data, wv[i].data);
            chk("w_strb", w_strb, wv[i].strb);
            chk("w_last", w_last, 1);
            chk("cli_w_ready_idle", cli_w_ready, 0);
            w_ready = 1'b1;
            #1;
            chk("cli_w_ready", cli_w_ready, 1 << wv[i].cli);
            tick();
            w_ready = 1'b0;
            b_phase(wv[i].cli);
            cli_w_valid = '0;
        end

        // two-beat write with w_ready stalled 3 cycles
        cli_w_valid = '0; cli_w_addr = '0; cli_w_size = '0; cli_w_data = '0; cli_w_len = '0;
        cli_w_valid[0] = 1'b1;
        cli_w_addr[0 +: AW] = 32'h0000_2000;
        cli_w_size[0 +: 3] = 3'd2;
        cli_w_len[0 +: LW] = 8'd1;
        cli_w_data[0 +: DW] = 32'h1111_1111;
        wait_aw(cyc);
        chk("stall_aw_latency", cyc, 1);
        aw_ready = 1'b1; tick(); aw_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_w_valid", w_valid, 1);
            chk("stall_w_data", w_data, 32'h1111_1111);
            chk("stall_w_last", w_last, 0);
            chk("stall_cli_w_ready", cli_w_ready, 0);
            tick();
        end
        chk("stall_w_strb", w_strb, 4'b1111);
        w_ready = 1'b1;
        #1;
        chk("beat1_cli_w_ready", cli_w_ready, 3'b001);
        chk("beat1_w_last", w_last, 0);
        tick();
        cli_w_data[0 +: DW] = 32'h2222_2222;
        #1;
        chk("beat2_w_data", w_data, 32'h2222_2222);
        chk("beat2_w_last", w_last, 1);
        chk("beat2_cli_w_ready", cli_w_ready, 3'b001);
        tick();
        w_ready = 1'b0;
        b_phase(0);
        cli_w_valid = '0;

        // concurrent read (client 0) and write (client 1)
        cli_r_valid = 3'b001;
        cli_r_addr[0 +: AW] = 32'h3000_0000;
        cli_r_len[0 +: LW] = 8'd0;
        cli_w_valid = 3'b010;
        cli_w_addr[AW +: AW] = 32'h4000_0000;
        cli_w_size[3 +: 3] = 3'd2;
        cli_w_len[LW +: LW] = 8'd0;
        cli_w_data[DW +: DW] = 32'h7777_0001;
        tick();
        chk("cc_ar_valid", ar_valid, 1);
        chk("cc_aw_valid", aw_valid, 1);
        chk("cc_ar_id", ar_id, 0);
        chk("cc_aw_id", aw_id, 1);
        ar_ready = 1'b1; aw_ready = 1'b1;
        tick();
        ar_ready = 1'b0; aw_ready = 1'b0;
        r_valid = 1'b1; r_last = 1'b1; r_data = 32'h9999_0000;
        w_ready = 1'b1;
        #1;
        chk("cc_cli_r_last", cli_r_last, 3'b001);
        chk("cc_cli_w_ready", cli_w_ready, 3'b010);
        chk("cc_w_data", w_data, 32'h7777_0001);
        tick();
        r_valid = 1'b0; r_last = 1'b0; w_ready = 1'b0;
        cli_r_valid = '0;
        b_phase(1);
        cli_w_valid = '0;
        #1;
        chk("cc_r_idle", r_ready, 0);
        chk("cc_w_idle", b_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
